// File: rtl/inst_fetch_responder_if.sv
// Fetch and loader bus between the core/host side (master) and the
// instruction responder (slave).
interface inst_fetch_responder_if;
  logic [31:0] inst_addr;
  logic [31:0] instruction;
  logic        inst_ready;
  logic        fetch_err;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  modport master (
    output inst_addr, ld_we, ld_addr, ld_data,
    input  instruction, inst_ready, fetch_err
  );

  modport slave (
    input  inst_addr, ld_we, ld_addr, ld_data,
    output instruction, inst_ready, fetch_err
  );
endinterface

// File: rtl/inst_fetch_responder.sv
// Instruction-side responder: single-port word array with programmable wait
// states, host loader port with priority, NOP + sticky error on bad fetches.
module inst_fetch_responder #(
  parameter int unsigned DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input logic                   clk,
  input logic                   rst_n,
  inst_fetch_responder_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [2:0]  CNT_INIT = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  logic [31:0] mem [DEPTH];

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] req_q, req_d;
  logic [31:0] instr_q, instr_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic [31:0] ld_off, rd_addr, rd_off, rd_word;
  logic        ld_ok, rd_err, complete;

  // Offsets are 32-bit unsigned, so addresses below BASE_ADDR wrap high and
  // fall out of range.
  assign ld_off = bus.ld_addr - BASE_ADDR;
  assign ld_ok  = (ld_off >> 2) < 32'(DEPTH);

  always_ff @(posedge clk) begin
    if (bus.ld_we && ld_ok) mem[ld_off[AW+1:2]] <= bus.ld_data;
  end

  // The array is read on the completion edge itself, so a loader write that
  // lands during WAIT is visible in the returned word.
  assign rd_addr = (state_q == S_WAIT) ? req_q : bus.inst_addr;
  assign rd_off  = rd_addr - BASE_ADDR;
  assign rd_err  = (rd_addr[1:0] != 2'b00) || ((rd_off >> 2) >= 32'(DEPTH));
  assign rd_word = mem[rd_off[AW+1:2]];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    instr_d  = instr_q;
    ready_d  = 1'b0;
    err_d    = err_q;
    complete = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (!bus.ld_we) begin
          req_d = bus.inst_addr;
          if (WAIT_STATES == 0) begin
            complete = 1'b1;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.inst_addr != req_q) begin
          req_d = bus.inst_addr;
          cnt_d = CNT_INIT;
        end else if (cnt_q == 3'd0) begin
          // A loader write owns the port this edge; retry next edge.
          if (!bus.ld_we) complete = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (complete) begin
      ready_d = 1'b1;
      state_d = S_RESP;
      instr_d = rd_err ? NOP_WORD : rd_word;
      if (rd_err) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      req_q   <= 32'd0;
      instr_q <= NOP_WORD;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign bus.instruction = instr_q;
  assign bus.inst_ready  = ready_q;
  assign bus.fetch_err   = err_q;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Scoreboard bench: three responders (0, 1, 2 wait states) share stimulus;
// one is selected per phase and its responses are matched against a queue.
module tb_inst_fetch_responder;
  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] W0    = 32'h0050_0093;
  localparam logic [31:0] W4    = 32'h0010_8113;
  localparam logic [31:0] W40   = 32'h00A0_0193;
  localparam logic [31:0] WDB   = 32'hDEAD_BEEF;
  localparam logic [31:0] W80   = 32'h1111_1111;

  logic        clk = 1'b0, rst_n = 1'b0, ld_we = 1'b0;
  logic [31:0] inst_addr = 32'd0, ld_addr = 32'd0, ld_data = 32'd0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inst_fetch_responder_if bus0();
  inst_fetch_responder_if bus1();
  inst_fetch_responder_if bus2();

  assign bus0.inst_addr = inst_addr; assign bus0.ld_we = ld_we;
  assign bus0.ld_addr   = ld_addr;   assign bus0.ld_data = ld_data;
  assign bus1.inst_addr = inst_addr; assign bus1.ld_we = ld_we;
  assign bus1.ld_addr   = ld_addr;   assign bus1.ld_data = ld_data;
  assign bus2.inst_addr = inst_addr; assign bus2.ld_we = ld_we;
  assign bus2.ld_addr   = ld_addr;   assign bus2.ld_data = ld_data;

  inst_fetch_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  inst_fetch_responder #(.DEPTH(DEPTH), .WAIT_STATES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  inst_fetch_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {int cyc; logic [31:0] data; logic err;} exp_t;
  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;
  int   sel = 0;
  bit   mon_en = 1'b0;

  logic        a_rdy, a_err;
  logic [31:0] a_ins;
  always_comb begin
    a_rdy = bus2.inst_ready; a_err = bus2.fetch_err; a_ins = bus2.instruction;
    case (sel)
      0: begin a_rdy = bus0.inst_ready; a_err = bus0.fetch_err; a_ins = bus0.instruction; end
      1: begin a_rdy = bus1.inst_ready; a_err = bus1.fetch_err; a_ins = bus1.instruction; end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic push(input int c, input logic [31:0] d, input logic e);
    exp_t x;
    x.cyc = c; x.data = d; x.err = e;
    sb.push_back(x);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic start(input int s, input logic [31:0] a, output int b);
    sel = s; inst_addr = a; rst_n = 1'b1; mon_en = 1'b1; b = cyc;
  endtask

  task automatic end_phase(input string nm);
    rst_n = 1'b0;
    tick();
    chk({nm, "_drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
    mon_en = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && a_rdy) begin
        n_chk++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_ready: dut%0d cyc %0d got %h err %b, expected no response",
                   sel, cyc, a_ins, a_err);
        end else begin
          e = sb.pop_front();
          if (cyc == e.cyc && a_ins === e.data && a_err === e.err) n_pass++;
          else $display("FAIL response: dut%0d got cyc %0d data %h err %b, expected cyc %0d data %h err %b",
                        sel, cyc, a_ins, a_err, e.cyc, e.data, e.err);
        end
      end
    end
  endtask

  initial begin
    int b;
    fork monitor(); join_none

    // Program load while reset is held; the out-of-range write must be dropped.
    tick(); tick();
    load(32'h0, W0);
    load(32'h4, W4);
    load(32'h40, W40);
    load(DEPTH * 4, 32'hBADB_AD00);
    tick();
    chk("rst_ready", {29'd0, bus0.inst_ready, bus1.inst_ready, bus2.inst_ready}, 32'd0);
    chk("rst_err",   {29'd0, bus0.fetch_err, bus1.fetch_err, bus2.fetch_err}, 32'd0);
    chk("rst_instr0", bus0.instruction, NOP);
    chk("rst_instr2", bus2.instruction, NOP);

    // Zero wait states: continuous ready, one cycle latency.
    start(0, 32'h0, b);
    push(b + 1, W0, 1'b0);
    tick(); inst_addr = 32'h4; push(b + 2, W4, 1'b0);
    tick();
    end_phase("ws0");

    // Two wait states, address held: one-cycle pulse in cycle 3.
    start(2, 32'h4, b);
    push(b + 3, W4, 1'b0);
    repeat (4) tick();
    chk("pulse_len", {31'd0, a_rdy}, 32'd0);
    end_phase("ws2");

    // Redirect after one cycle restarts the count.
    start(2, 32'h4, b);
    tick(); inst_addr = 32'h40; push(b + 4, W40, 1'b0);
    repeat (4) tick();
    end_phase("redirect");

    // Loader write on the completion edge defers it and is visible.
    start(1, 32'h4, b);
    push(b + 3, WDB, 1'b0);
    tick(); ld_we = 1'b1; ld_addr = 32'h4; ld_data = WDB;
    tick(); ld_we = 1'b0;
    tick(); tick();
    end_phase("ld_defer");

    // Zero wait states with a loader conflict.
    start(0, 32'h40, b);
    push(b + 1, W40, 1'b0);
    tick(); ld_we = 1'b1; ld_addr = 32'h80; ld_data = W80;
    tick(); ld_we = 1'b0; inst_addr = 32'h80;
    push(b + 3, W80, 1'b0);
    tick(); push(b + 4, W80, 1'b0);
    tick();
    end_phase("ws0_defer");

    // Misaligned then out-of-range fetch; error is sticky.
    start(1, 32'h2, b);
    push(b + 2, NOP, 1'b1);
    tick(); tick(); inst_addr = DEPTH * 4; push(b + 4, NOP, 1'b1);
    tick(); tick(); inst_addr = 32'h0;     push(b + 6, W0, 1'b1);
    tick(); tick(); tick();
    end_phase("err");
    chk("err_cleared", {31'd0, bus1.fetch_err}, 32'd0);

    // Reset mid-WAIT clears outputs; the array survives.
    start(2, 32'h0, b);
    push(b + 3, W0, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_ready", {31'd0, a_rdy}, 32'd0);
    chk("midrst_instr", a_ins, NOP);
    chk("midrst_err", {31'd0, a_err}, 32'd0);
    rst_n = 1'b1; b = cyc;
    push(b + 3, W0, 1'b0);
    repeat (4) tick();
    end_phase("midrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
